// File: rtl/mem8x8_pkg.sv
// Shared types and constants for the 8x8 memory access controller.
// Holds the state encoding, the strobe levels and the per-state output decode.
package mem8x8_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    READ     = 2'b01,
    READ_OUT = 2'b10,
    WRITE    = 2'b11
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic valid_of(input state_t s);
    logic v;
    case (s)
      READ_OUT: v = 1'b1;
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic rw_of(input state_t s);
    logic r;
    case (s)
      WRITE:   r = RW_WRITE;
      default: r = RW_READ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem8x8_if.sv
// Control-pin bundle between the external memory pins and the access controller.
// The master drives the request; the slave returns the buffer enable and strobe.
interface mem8x8_if;
  logic sel;
  logic op;
  logic valid;
  logic rw;

  modport master (output sel, output op, input valid, input rw);
  modport slave  (input sel, input op, output valid, output rw);
endinterface

// File: rtl/mem8x8_fsm.sv
// Moore access controller sequencing single-word reads and writes of the 8x8 array.
// Outputs come straight from flops loaded with the decode of the next state.
module mem8x8_fsm
  import mem8x8_pkg::*;
(
  input  logic     clkPE,
  input  logic     rst_n,
  mem8x8_if.slave  bus
);

  state_t state_r;
  state_t next_s;
  logic   valid_r;
  logic   rw_r;

  // State register plus registered output decode
  always_ff @(posedge clkPE or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      rw_r    <= RW_READ;
    end else begin
      state_r <= next_s;
      valid_r <= valid_of(next_s);
      rw_r    <= rw_of(next_s);
    end
  end

  // Next-state logic; a read already started completes regardless of op
  always_comb begin
    next_s = IDLE;
    case (state_r)
      READ: begin
        if (bus.sel) begin
          next_s = READ_OUT;
        end else begin
          next_s = IDLE;
        end
      end
      IDLE, READ_OUT, WRITE: begin
        if (!bus.sel) begin
          next_s = IDLE;
        end else if (bus.op) begin
          next_s = WRITE;
        end else begin
          next_s = READ;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  assign bus.valid = valid_r;
  assign bus.rw    = rw_r;

endmodule

// File: tb/tb_mem8x8_fsm.sv
// Directed bench for mem8x8_fsm: literal checks per step plus a transaction-level
// model compared against the outputs on every falling clock edge.
module tb_mem8x8_fsm;

  logic clkPE;
  logic rst_n;
  int   checks;
  int   errors;

  mem8x8_if bus ();

  mem8x8_fsm dut (
    .clkPE (clkPE),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clkPE = 1'b0;
  always #5 clkPE = ~clkPE;

  // Model: a selected cycle either finishes a pending read, writes, or starts a read
  logic m_valid;
  logic m_rw;
  logic m_pend;

  always @(posedge clkPE or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_rw    <= 1'b1;
      m_pend  <= 1'b0;
    end else if (!bus.sel) begin
      m_valid <= 1'b0;
      m_rw    <= 1'b1;
      m_pend  <= 1'b0;
    end else if (m_pend) begin
      m_valid <= 1'b1;
      m_rw    <= 1'b1;
      m_pend  <= 1'b0;
    end else if (bus.op) begin
      m_valid <= 1'b0;
      m_rw    <= 1'b0;
      m_pend  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_rw    <= 1'b1;
      m_pend  <= 1'b1;
    end
  end

  always @(negedge clkPE) begin
    checks = checks + 1;
    if (bus.valid !== m_valid || bus.rw !== m_rw) begin
      errors = errors + 1;
      $display("FAIL model t=%0t valid=%b rw=%b expected valid=%b rw=%b",
               $time, bus.valid, bus.rw, m_valid, m_rw);
    end
  end

  task automatic check(input string name, input logic exp_valid, input logic exp_rw);
    checks = checks + 1;
    if (bus.valid !== exp_valid || bus.rw !== exp_rw) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t valid=%b rw=%b expected valid=%b rw=%b",
               name, $time, bus.valid, bus.rw, exp_valid, exp_rw);
    end
  endtask

  // Apply inputs, then return 1 time unit after the edge that sampled them
  task automatic cyc(input logic s, input logic o);
    bus.sel = s;
    bus.op  = o;
    @(posedge clkPE);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    bus.sel = 1'b0;
    bus.op  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      check("held_in_reset", 1'b0, 1'b1);
    end
    rst_n = 1'b1;

    // Simple read held selected
    cyc(1'b1, 1'b0);
    check("read_n", 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("read_n1_valid", 1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("read_n2_again", 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check("deselect_idle", 1'b0, 1'b1);

    // op ignored in READ, abort by deselect, then clean read
    cyc(1'b1, 1'b0);
    check("seq_e1_read", 1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check("seq_e2_readout", 1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("seq_e3_read", 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check("seq_e4_abort", 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("seq_e5_read", 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("seq_e6_readout", 1'b1, 1'b1);

    // Write burst straight out of READ_OUT
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      check("write_burst", 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1);
    check("write_end", 1'b0, 1'b1);

    // Write-to-read turnaround
    cyc(1'b1, 1'b1);
    check("turn_write", 1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("turn_read", 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("turn_readout", 1'b1, 1'b1);

    // Reset in the middle of a write, then in the middle of a read
    cyc(1'b1, 1'b1);
    check("pre_reset_write", 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_write", 1'b0, 1'b1);
    @(posedge clkPE);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    check("reread_start", 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_read", 1'b0, 1'b1);
    @(posedge clkPE);
    #1;
    check("no_valid_in_reset", 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    check("after_reset_read", 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("after_reset_valid", 1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    check("final_idle", 1'b0, 1'b1);

    @(negedge clkPE);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
